// File: rtl/stream_comparator_if.sv
// Operand/result stream bundle for stream_comparator: producer side, consumer side and statistics.
// The DUT takes the slave modport; the producer/consumer/testbench drives through master.
interface stream_comparator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             e;
    logic             g;
    logic             l;
    logic             clear;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] gt_count;
    logic [CNT_W-1:0] lt_count;

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready, clear,
        output in_ready, out_valid, e, g, l, eq_count, gt_count, lt_count
    );

    modport master (
        output in_valid, a, b, signed_mode, out_ready, clear,
        input  in_ready, out_valid, e, g, l, eq_count, gt_count, lt_count
    );
endinterface

// File: rtl/stream_comparator.sv
// Registered signed/unsigned magnitude comparator with valid/ready flow control.
// Define STREAM_CMP_STATS_EN to build the saturating eq/gt/lt result counters and their clear.
module stream_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    stream_comparator_if.slave bus
);
    logic             out_valid_q, out_valid_d;
    logic             e_q, e_d, g_q, g_d, l_q, l_d;
    logic             accept;
    logic [WIDTH-1:0] sign_mask, a_key, b_key;
    logic             cmp_eq, cmp_lt;

    // The output register is free when empty or being drained this cycle.
    assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_mask = WIDTH'(bus.signed_mode) << (WIDTH - 1);
    assign a_key     = bus.a ^ sign_mask;
    assign b_key     = bus.b ^ sign_mask;
    assign cmp_eq    = (bus.a == bus.b);
    assign cmp_lt    = (a_key < b_key);

    always_comb begin
        out_valid_d = out_valid_q;
        e_d         = e_q;
        g_d         = g_q;
        l_d         = l_q;
        if (accept) begin
            out_valid_d = 1'b1;
            e_d         = cmp_eq;
            l_d         = cmp_lt;
            g_d         = !cmp_eq && !cmp_lt;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            e_q         <= 1'b0;
            g_q         <= 1'b0;
            l_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            e_q         <= e_d;
            g_q         <= g_d;
            l_q         <= l_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.e         = e_q;
    assign bus.g         = g_q;
    assign bus.l         = l_q;

`ifdef STREAM_CMP_STATS_EN
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d, gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_base, gt_base, lt_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Clear takes effect before the increment of a coincident accept.
    always_comb begin
        eq_base  = bus.clear ? '0 : eq_cnt_q;
        gt_base  = bus.clear ? '0 : gt_cnt_q;
        lt_base  = bus.clear ? '0 : lt_cnt_q;
        eq_cnt_d = eq_base;
        gt_cnt_d = gt_base;
        lt_cnt_d = lt_base;
        if (accept) begin
            if (cmp_eq)      eq_cnt_d = sat_inc(eq_base);
            else if (cmp_lt) lt_cnt_d = sat_inc(lt_base);
            else             gt_cnt_d = sat_inc(gt_base);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_cnt_q <= '0;
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            eq_cnt_q <= eq_cnt_d;
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
        end
    end

    assign bus.eq_count = eq_cnt_q;
    assign bus.gt_count = gt_cnt_q;
    assign bus.lt_count = lt_cnt_q;
`else
    logic unused_clear;
    assign unused_clear = bus.clear;
    assign bus.eq_count = '0;
    assign bus.gt_count = '0;
    assign bus.lt_count = '0;
`endif
endmodule

// File: tb/tb_stream_comparator.sv
// Scoreboard bench for stream_comparator: driver predicts results from integer compares,
// a negedge monitor pops and checks every presented result and the counters.
module tb_stream_comparator;
    localparam int W    = 8;
    localparam int C    = 2;
    localparam int CMAX = (1 << C) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_comparator_if #(.WIDTH(W), .CNT_W(C)) bus();
    stream_comparator #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [2:0] sb[$];
    int  checks = 0;
    int  passes = 0;
    int  eqc = 0, gtc = 0, ltc = 0;
    bit  mon_en = 0;
    bit  prev_rst = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference compare on plain integers: {e, g, l}
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm);
        int vx, vy;
        vx = int'(x);
        vy = int'(y);
        if (sm && vx >= (1 << (W - 1))) vx -= (1 << W);
        if (sm && vy >= (1 << (W - 1))) vy -= (1 << W);
        return {vx == vy, vx > vy, vx < vy};
    endfunction

    function automatic int bump(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    // One clock cycle of stimulus; acc reports whether the model expects an accept.
    task automatic cyc(input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv, input bit sm,
                       input bit ordy, input bit clr, input bit r, output bit acc);
        bit vexp;
        logic [2:0] res;
        @(posedge clk);
        #1;
        rst             = r;
        bus.in_valid    = iv;
        bus.a           = av;
        bus.b           = bv;
        bus.signed_mode = sm;
        bus.out_ready   = ordy;
        bus.clear       = clr;
        vexp = (sb.size() != 0);
        acc  = iv && !r && (!vexp || ordy);
        @(negedge clk);
        if (mon_en) chk("in_ready", bus.in_ready, !r && (!vexp || ordy));
        if (prev_rst) chk("rst_egl", {bus.e, bus.g, bus.l}, 3'b000);
        #1;
        if (r) begin
            sb.delete();
            eqc = 0; gtc = 0; ltc = 0;
        end else begin
            if (clr) begin
                eqc = 0; gtc = 0; ltc = 0;
            end
            if (acc) begin
                res = ref_cmp(av, bv, sm);
                sb.push_back(res);
                if (res[2]) eqc = bump(eqc);
                if (res[1]) gtc = bump(gtc);
                if (res[0]) ltc = bump(ltc);
            end
        end
        prev_rst = r;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", bus.out_valid, sb.size() != 0);
            if (bus.out_valid && sb.size() != 0) begin
                chk("egl", {bus.e, bus.g, bus.l}, sb[0]);
                chk("onehot", $countones({bus.e, bus.g, bus.l}), 1);
                if (bus.out_ready) void'(sb.pop_front());
            end
`ifdef STREAM_CMP_STATS_EN
            chk("eq_count", bus.eq_count, eqc);
            chk("gt_count", bus.gt_count, gtc);
            chk("lt_count", bus.lt_count, ltc);
`else
            chk("eq_count", bus.eq_count, 0);
            chk("gt_count", bus.gt_count, 0);
            chk("lt_count", bus.lt_count, 0);
`endif
        end
    end

    initial begin
        bit acc;
        bit rdy_pat[6] = '{1, 0, 0, 1, 1, 0};
        logic [W-1:0] ra, rb;
        int k, guard;

        rst = 1'b1;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.signed_mode = 0;
        bus.out_ready = 0; bus.clear = 0;
        cyc(1, 8'h11, 8'h22, 0, 0, 0, 1, acc);
        mon_en = 1;
        cyc(1, 8'h11, 8'h22, 0, 0, 0, 1, acc);

        // First cycle after reset: idle, in_ready must already be high.
        cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Unsigned/signed split on 0x80 vs 0x01
        cyc(1, 8'h80, 8'h01, 0, 1, 0, 0, acc);
        cyc(1, 8'h80, 8'h01, 1, 1, 0, 0, acc);
        cyc(1, 8'h7F, 8'h80, 1, 1, 0, 0, acc);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Back-to-back with backpressure: a pair advances only once accepted.
        k = 0; guard = 0;
        while (k < 5 && guard < 50) begin
            ra = W'(k * 37 + 3);
            rb = W'(k * 11 + 40);
            cyc(1, ra, rb, k[0], rdy_pat[guard % 6], 0, 0, acc);
            if (acc) k++;
            guard++;
        end
        chk("bp_done", k, 5);
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Full throughput with out_ready held high
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            cyc(1, ra, rb, bit'($urandom_range(0, 1)), 1, 0, 0, acc);
            chk("tput_acc", acc, 1);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Saturation then clear coincident with an accept
        cyc(0, 0, 0, 0, 1, 1, 0, acc);
        repeat (5) cyc(1, 8'd3, 8'd3, 0, 1, 0, 0, acc);
        cyc(1, 8'd5, 8'd2, 0, 1, 1, 0, acc);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Reset while a result is stalled
        cyc(1, 8'd9, 8'd4, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, acc);
        cyc(1, 8'd1, 8'd2, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 1, 0, 0, acc);

        // Random traffic with random stalls and occasional clears
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            cyc(bit'($urandom_range(0, 3) != 0), ra, rb, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0), 0, acc);
        end

        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0, acc);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
